// File: rtl/apb_event_arbiter.sv
// apb_event_arbiter: counts events from four sources and reports each
// pending source to an APB slave as a single write transfer. Sources are
// served round-robin. A transfer that ends in a slave error or a timeout
// is counted and dropped, never retried.
module apb_event_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'hCAFE_0000,
    parameter int          CNT_W     = 8,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  event_i,
    output logic        apb_psel_o,
    output logic        apb_penable_o,
    output logic [31:0] apb_paddr_o,
    output logic        apb_pwrite_o,
    output logic [31:0] apb_pwdata_o,
    input  logic        apb_pready_i,
    input  logic        apb_pslverr_i,
    output logic [7:0]  err_count_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       ACC_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       pending;
    logic [1:0]       last_grant;
    logic [1:0]       grant_idx;
    logic [1:0]       probe;
    logic             grant_valid;
    logic             take_grant;
    logic             cooldown;
    logic [7:0]       acc_cnt;
    logic [15:0]      cnt_ext;
    logic             timeout_hit;
    logic             slave_err;
    logic             xfer_done;

    // A source has work to report whenever its counter is nonzero.
    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        pending = '0;
        for (int n = 0; n < 4; n++) begin
            pending[n] = (cnt[n] != '0);
        end
    end

    // Round-robin pick: first pending source after the last one granted.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        probe       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            probe = last_grant + 2'(k);
            if (!grant_valid && pending[probe]) begin
                grant_valid = 1'b1;
                grant_idx   = probe;
            end
        end
    end

    // Grant qualification and ACCESS-phase completion conditions.
    always_comb begin
        take_grant  = (state == IDLE) && !cooldown && grant_valid;
        cnt_ext     = 16'(cnt[grant_idx]);
        timeout_hit = (state == ACCESS) && !apb_pready_i && (acc_cnt == ACC_LAST);
        slave_err   = (state == ACCESS) && apb_pready_i && apb_pslverr_i;
        xfer_done   = (state == ACCESS) && (apb_pready_i || timeout_hit);
    end

    // Per-source saturating event counters; the granted one restarts from
    // this cycle's event so nothing arriving on the grant cycle is lost.
    // NOTE: the counters are a handful of flops, not a RAM, so they are reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (take_grant && (grant_idx == 2'(n))) begin
                    cnt[n] <= CNT_W'(event_i[n]);
                end else if (event_i[n] && (cnt[n] != CNT_MAX)) begin
                    cnt[n] <= cnt[n] + 1'b1;
                end
            end
        end
    end

    // Transfer FSM with registered APB outputs.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            apb_psel_o    <= 1'b0;
            apb_penable_o <= 1'b0;
            apb_pwrite_o  <= 1'b0;
            apb_paddr_o   <= '0;
            apb_pwdata_o  <= '0;
            last_grant    <= 2'd3;
            cooldown      <= 1'b0;
            acc_cnt       <= '0;
            timeout_o     <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            cooldown  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_grant) begin
                        state        <= SETUP;
                        apb_psel_o   <= 1'b1;
                        apb_pwrite_o <= 1'b1;
                        apb_paddr_o  <= BASE_ADDR + {28'h0, grant_idx, 2'b00};
                        apb_pwdata_o <= {14'h0, grant_idx, cnt_ext};
                        last_grant   <= grant_idx;
                    end
                end
                SETUP: begin
                    state         <= ACCESS;
                    apb_penable_o <= 1'b1;
                    acc_cnt       <= '0;
                end
                ACCESS: begin
                    if (xfer_done) begin
                        state         <= IDLE;
                        apb_psel_o    <= 1'b0;
                        apb_penable_o <= 1'b0;
                        apb_pwrite_o  <= 1'b0;
                        apb_paddr_o   <= '0;
                        apb_pwdata_o  <= '0;
                        cooldown      <= 1'b1;
                        timeout_o     <= timeout_hit;
                    end else begin
                        acc_cnt <= acc_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of transfers lost to slave error or timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_o <= '0;
        end else if ((slave_err || timeout_hit) && (err_count_o != 8'hFF)) begin
            err_count_o <= err_count_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_apb_event_arbiter.sv
// Randomised and directed bench for apb_event_arbiter, compared cycle by
// cycle against a transaction-level reference model.
module tb_apb_event_arbiter;

    localparam logic [31:0] BASE = 32'hCAFE_0000;
    localparam int          CW   = 8;
    localparam int          TO   = 16;
    localparam int          CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  event_i;
    logic        pready, pslverr;
    logic        psel, penable, pwrite, timeout;
    logic [31:0] paddr, pwdata;
    logic [7:0]  err_count;

    // Second instance with a long timeout, used for counter saturation.
    logic [3:0]  ev_l;
    logic        pready_l, pslverr_l;
    logic        psel_l, penable_l, pwrite_l, timeout_l;
    logic [31:0] paddr_l, pwdata_l;
    logic [7:0]  err_l;

    always #5 clk = ~clk;

    apb_event_arbiter #(.BASE_ADDR(BASE), .CNT_W(CW), .TIMEOUT(TO)) u_dut (
        .clk(clk), .reset(reset), .event_i(event_i),
        .apb_psel_o(psel), .apb_penable_o(penable), .apb_paddr_o(paddr),
        .apb_pwrite_o(pwrite), .apb_pwdata_o(pwdata),
        .apb_pready_i(pready), .apb_pslverr_i(pslverr),
        .err_count_o(err_count), .timeout_o(timeout)
    );

    apb_event_arbiter #(.BASE_ADDR(BASE), .CNT_W(CW), .TIMEOUT(255)) u_dut_long (
        .clk(clk), .reset(reset), .event_i(ev_l),
        .apb_psel_o(psel_l), .apb_penable_o(penable_l), .apb_paddr_o(paddr_l),
        .apb_pwrite_o(pwrite_l), .apb_pwdata_o(pwdata_l),
        .apb_pready_i(pready_l), .apb_pslverr_i(pslverr_l),
        .err_count_o(err_l), .timeout_o(timeout_l)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = setup, 2 = access.
    int          m_cnt [4];
    int          m_phase, m_last, m_acc, m_err, m_src;
    bit          m_cool, m_to;
    logic [31:0] m_data;

    task automatic model_reset();
        for (int s = 0; s < 4; s++) m_cnt[s] = 0;
        m_phase = 0; m_last = 3; m_acc = 0; m_err = 0; m_src = 0;
        m_cool = 0; m_to = 0; m_data = '0;
    endtask

    task automatic model_step();
        int  grant;
        bit  fire;
        grant = -1;
        fire  = 0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_phase == 0) begin
            if (!m_cool) begin
                for (int k = 1; k <= 4; k++) begin
                    int s;
                    s = (m_last + k) % 4;
                    if (grant < 0 && m_cnt[s] > 0) grant = s;
                end
            end
            m_cool = 0;
            if (grant >= 0) begin
                m_src   = grant;
                m_data  = (32'(grant) << 16) | 32'(m_cnt[grant]);
                m_last  = grant;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_acc   = 0;
        end else begin
            m_acc++;
            if (pready) begin
                if (pslverr) m_err = (m_err < 255) ? m_err + 1 : 255;
                m_phase = 0;
                m_cool  = 1;
            end else if (m_acc == TO) begin
                m_err   = (m_err < 255) ? m_err + 1 : 255;
                fire    = 1;
                m_phase = 0;
                m_cool  = 1;
            end
        end
        for (int s = 0; s < 4; s++) begin
            if (s == grant) m_cnt[s] = int'(event_i[s]);
            else if (event_i[s]) m_cnt[s] = (m_cnt[s] < CMAX) ? m_cnt[s] + 1 : CMAX;
        end
        m_to = fire;
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("psel",      32'(psel),      32'(m_phase != 0));
        check("penable",   32'(penable),   32'(m_phase == 2));
        check("pwrite",    32'(pwrite),    32'(m_phase != 0));
        check("paddr",     paddr,          (m_phase != 0) ? BASE + 32'(4 * m_src) : 32'h0);
        check("pwdata",    pwdata,         (m_phase != 0) ? m_data : 32'h0);
        check("err_count", 32'(err_count), 32'(m_err));
        check("timeout",   32'(timeout),   32'(m_to));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] q_addr[$];
        logic [31:0] q_data[$];
        int          n_setup, n_access, n_pulse;
        bit          found, slow;

        reset = 1'b1; event_i = '0; pready = 1'b0; pslverr = 1'b0;
        ev_l = '0; pready_l = 1'b0; pslverr_l = 1'b0;
        model_reset();

        // Reset state
        #3;
        check("rst_psel",    32'(psel),      32'h0);
        check("rst_penable", 32'(penable),   32'h0);
        check("rst_pwrite",  32'(pwrite),    32'h0);
        check("rst_paddr",   paddr,          32'h0);
        check("rst_pwdata",  pwdata,         32'h0);
        check("rst_err",     32'(err_count), 32'h0);
        check("rst_timeout", 32'(timeout),   32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Single event on source 0, slave always ready
        pready = 1'b1;
        event_i = 4'b0001;
        tick();
        event_i = 4'b0000;
        tick();
        check("single_setup_psel",    32'(psel),    32'h1);
        check("single_setup_penable", 32'(penable), 32'h0);
        check("single_setup_paddr",   paddr,        32'hCAFE_0000);
        check("single_setup_pwdata",  pwdata,       32'h0000_0001);
        tick();
        check("single_access_penable", 32'(penable), 32'h1);
        tick();
        check("single_idle_psel", 32'(psel), 32'h0);

        // All four sources at once: served 0,1,2,3
        do_reset();
        pready = 1'b1;
        event_i = 4'b1111;
        tick();
        event_i = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (psel && !penable) begin
                q_addr.push_back(paddr);
                q_data.push_back(pwdata);
            end
        end
        check("rr_transfer_count", 32'(q_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("rr_addr", (i < q_addr.size()) ? q_addr[i] : 32'hx, BASE + 32'(4 * i));
            check("rr_data", (i < q_data.size()) ? q_data[i] : 32'hx, (32'(i) << 16) | 32'h1);
        end

        // Slave error: counted once, not retried
        do_reset();
        pready = 1'b1;
        pslverr = 1'b1;
        event_i = 4'b0010;
        tick();
        event_i = 4'b0000;
        n_setup = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (psel && !penable) n_setup++;
        end
        check("slverr_setups", 32'(n_setup), 32'd1);
        check("slverr_err_count", 32'(err_count), 32'd1);
        pslverr = 1'b0;

        // Timeout: slave never ready
        do_reset();
        pready = 1'b0;
        event_i = 4'b0001;
        tick();
        event_i = 4'b0000;
        n_access = 0;
        n_pulse = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (penable) n_access++;
            if (timeout) n_pulse++;
        end
        check("timeout_access_cycles", 32'(n_access), 32'd16);
        check("timeout_pulses", 32'(n_pulse), 32'd1);
        check("timeout_err_count", 32'(err_count), 32'd1);

        // Counter saturation on the long-timeout instance
        do_reset();
        q_data.delete();
        ev_l = 4'b0100;
        pready_l = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (psel_l && !penable_l) q_data.push_back(pwdata_l);
        end
        ev_l = 4'b0000;
        check("sat_transfer_count_ge2", 32'(q_data.size() >= 2), 32'd1);
        check("sat_first_pwdata",  (q_data.size() > 0) ? q_data[0] : 32'hx, 32'h0002_0001);
        check("sat_second_pwdata", (q_data.size() > 1) ? q_data[1] : 32'hx, 32'h0002_00FF);

        // Randomised traffic against the model
        do_reset();
        slow = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) slow = ($urandom_range(0, 2) == 0);
            event_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            pready  = slow ? ($urandom_range(0, 24) == 0) : 1'($urandom_range(0, 1));
            pslverr = ($urandom_range(0, 3) == 0);
            tick();
        end

        // Reset in the middle of ACCESS
        event_i = 4'b1111;
        pready = 1'b0;
        pslverr = 1'b0;
        tick();
        event_i = 4'b0000;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (penable) found = 1;
        end
        check("midrst_access_reached", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_psel",    32'(psel),      32'h0);
        check("midrst_penable", 32'(penable),   32'h0);
        check("midrst_pwrite",  32'(pwrite),    32'h0);
        check("midrst_paddr",   paddr,          32'h0);
        check("midrst_pwdata",  pwdata,         32'h0);
        check("midrst_err",     32'(err_count), 32'h0);
        check("midrst_timeout", 32'(timeout),   32'h0);
        tick();
        reset = 1'b0;
        pready = 1'b1;
        event_i = 4'b1111;
        tick();
        event_i = 4'b0000;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (psel) found = 1;
        end
        check("midrst_regrant_seen", 32'(found), 32'd1);
        check("midrst_first_src0", paddr, 32'hCAFE_0000);
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
